// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: valid/ready request in, one operation in flight,
// single-cycle ops via a combinational ALU, DIV/MOD via a bit-serial restoring divider.
package alu_sequencer_pkg;
  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_HLT = 5'd1;
  localparam logic [4:0] OP_NOT = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4;
  localparam logic [4:0] OP_NEG = 5'd5;
  localparam logic [4:0] OP_ADD = 5'd6;
  localparam logic [4:0] OP_SUB = 5'd7;
  localparam logic [4:0] OP_MUL = 5'd8;
  localparam logic [4:0] OP_DIV = 5'd9;
  localparam logic [4:0] OP_MOD = 5'd10;
endpackage

module alu
  import alu_sequencer_pkg::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic [4:0]           opcode,
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] b,
  output logic [BITS_DATA-1:0] y,
  output logic                 c,
  output logic                 s,
  output logic                 o,
  output logic                 z,
  output logic                 illegal
);
  localparam int MSB = BITS_DATA - 1;

  logic [BITS_DATA:0] sum;

  // SUB/NEG report borrow in C; DIV/MOD only resolve the divide-by-zero case here.
  always_comb begin
    y       = '0;
    c       = 1'b0;
    o       = 1'b0;
    illegal = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    case (opcode)
      OP_NOP, OP_HLT: ;
      OP_NOT: y = ~a;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_NEG: begin
        y = '0 - a;
        c = |a;
        o = a[MSB] & y[MSB];
      end
      OP_ADD: begin
        y = sum[MSB:0];
        c = sum[BITS_DATA];
        o = (a[MSB] == b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y = a - b;
        c = (a < b);
        o = (a[MSB] != b[MSB]) && (y[MSB] != a[MSB]);
      end
      OP_MUL: y = a * b;
      OP_DIV: if (b == '0) begin y = '1; o = 1'b1; end
      OP_MOD: if (b == '0) begin y = a;  o = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  assign s = y[MSB];
  assign z = ~|y;
endmodule

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int BITS_DATA = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           opcode,
  input  logic [BITS_DATA-1:0] op_a,
  input  logic [BITS_DATA-1:0] op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITS_DATA-1:0] result,
  output logic                 C,
  output logic                 S,
  output logic                 O,
  output logic                 Z,
  output logic                 err,
  output logic                 halted,
  output logic                 busy
);
  localparam int MSB = BITS_DATA - 1;
  localparam int CW  = $clog2(BITS_DATA + 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_DONE, S_HALT} state_t;

  state_t                 state, state_nxt;
  logic [4:0]             opc_q;
  logic [BITS_DATA-1:0]   a_q, b_q;
  logic [BITS_DATA-1:0]   rem_q, quo_q, rem_nxt, quo_nxt, div_res;
  logic [BITS_DATA:0]     trial;
  logic [CW-1:0]          cnt_q;
  logic                   accept, div_last;
  logic [BITS_DATA-1:0]   alu_y;
  logic                   alu_c, alu_s, alu_o, alu_z, alu_ill;

  assign accept   = in_valid & in_ready;
  assign div_last = (cnt_q == CW'(BITS_DATA - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        case (opcode)
          OP_NOP:         state_nxt = S_IDLE;
          OP_HLT:         state_nxt = S_HALT;
          OP_DIV, OP_MOD: state_nxt = (op_b != '0) ? S_DIV : S_EXEC;
          default:        state_nxt = S_EXEC;
        endcase
      end
      S_EXEC:  state_nxt = S_DONE;
      S_DIV:   if (div_last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE:        in_ready = 1'b1;
      S_EXEC, S_DIV: busy = 1'b1;
      S_DONE:        begin busy = 1'b1; out_valid = 1'b1; end
      S_HALT:        halted = 1'b1;
      default: ;
    endcase
  end

  alu #(.BITS_DATA(BITS_DATA)) u_alu (
    .opcode  (opc_q),
    .a       (a_q),
    .b       (b_q),
    .y       (alu_y),
    .c       (alu_c),
    .s       (alu_s),
    .o       (alu_o),
    .z       (alu_z),
    .illegal (alu_ill)
  );

  // One restoring step: shift the next dividend bit in, keep the difference if it fits.
  always_comb begin
    trial = {rem_q, quo_q[MSB]} - {1'b0, b_q};
    if (trial[BITS_DATA]) begin
      rem_nxt = {rem_q[MSB-1:0], quo_q[MSB]};
      quo_nxt = {quo_q[MSB-1:0], 1'b0};
    end else begin
      rem_nxt = trial[MSB:0];
      quo_nxt = {quo_q[MSB-1:0], 1'b1};
    end
    div_res = (opc_q == OP_MOD) ? rem_nxt : quo_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      C      <= 1'b0;
      S      <= 1'b0;
      O      <= 1'b0;
      Z      <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          opc_q <= opcode;
          a_q   <= op_a;
          b_q   <= op_b;
          rem_q <= '0;
          quo_q <= op_a;
          cnt_q <= '0;
        end
        S_EXEC: begin
          result <= alu_y;
          C      <= alu_c & (opc_q != OP_MUL);
          S      <= alu_s;
          O      <= alu_o & (opc_q != OP_MUL);
          Z      <= alu_z;
          err    <= alu_ill;
        end
        S_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q + CW'(1);
          if (div_last) begin
            result <= div_res;
            C      <= 1'b0;
            S      <= div_res[MSB];
            O      <= 1'b0;
            Z      <= ~|div_res;
            err    <= 1'b0;
          end
        end
        S_DONE: if (out_ready) err <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
